axi_rd_burst_gen: RTL and testbench

Converts read commands popped from the AXI command FIFO into AXI4 read-address (AR) bursts. Each command is a start address plus a length in beats. The block splits it into INCR bursts that never exceed MAX_BURST beats and never cross a 4 KB boundary. It sits directly downstream of the command sync FIFO: its slave handshake connects to the FIFO's m_valid/m_ready/m_data. It drives the AR channel and snoops the R channel to track outstanding bursts.

---
 rtl/axi_rd_burst_gen.sv | 105 ++++++++++
 tb/tb_axi_rd_burst_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_burst_gen.sv
// axi_rd_burst_gen: splits {addr,len} read commands into AXI4 INCR AR bursts bounded by MAX_BURST and 4 KB pages.
module axi_rd_burst_gen #(
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int DATA_BYTES      = 4,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [ADDR_WIDTH+LEN_WIDTH-1:0] s_data,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  output logic [ADDR_WIDTH-1:0]           m_araddr,
  output logic [7:0]                      m_arlen,
  output logic [2:0]                      m_arsize,
  output logic [1:0]                      m_arburst,
  input  logic                            m_rvalid,
  input  logic                            m_rready,
  input  logic                            m_rlast,
  output logic                            busy,
  output logic                            cmd_done,
  output logic                            err_underflow
);
  localparam int LOG_DB = $clog2(DATA_BYTES);
  localparam int OW     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int CW     = (LEN_WIDTH > 13 ? LEN_WIDTH : 13) + 1;
  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DRAIN} state_t;
  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cur_addr, s_addr;
  logic [LEN_WIDTH-1:0]  rem, rem_nxt, s_len;
  logic [7:0]            arlen;
  logic [8:0]            nb;
  logic [12:0]           bnd;
  logic [CW-1:0]         rem_w, bnd_w, cap_w, min_rb, nb_w;
  logic [OW-1:0]         outstanding, out_n;
  logic                  arvalid_q, accept, ar_hs, r_last;
  assign s_addr    = s_data[ADDR_WIDTH+LEN_WIDTH-1:LEN_WIDTH];
  assign s_len     = s_data[LEN_WIDTH-1:0];
  assign accept    = s_valid && (state == IDLE);
  assign ar_hs     = arvalid_q && m_arready;
  assign r_last    = m_rvalid && m_rready && m_rlast;
  assign nb        = {1'b0, arlen} + 9'd1;
  assign rem_nxt   = rem - LEN_WIDTH'(nb);
  assign s_ready   = (state == IDLE);
  assign busy      = (state != IDLE);
  assign m_arvalid = arvalid_q;
  assign m_araddr  = cur_addr;
  assign m_arlen   = arlen;
  assign m_arsize  = 3'(LOG_DB);
  assign m_arburst = 2'b01;
  // Beats left before the 4 KB page ends; never zero since cur_addr is beat-aligned.
  always_comb begin
    bnd    = (13'd4096 - {1'b0, cur_addr[11:0]}) >> LOG_DB;
    rem_w  = CW'(rem);
    bnd_w  = CW'(bnd);
    cap_w  = CW'(MAX_BURST);
    min_rb = (rem_w < bnd_w) ? rem_w : bnd_w;
    nb_w   = (min_rb < cap_w) ? min_rb : cap_w;
  end
  always_comb begin
    out_n = (ar_hs && !r_last) ? outstanding + OW'(1) :
            (!ar_hs && r_last && outstanding != '0) ? outstanding - OW'(1) : outstanding;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (accept && s_len != '0) ? CALC : IDLE;
      CALC:    state_n = ISSUE;
      ISSUE:   state_n = ar_hs ? ((rem_nxt == '0) ? DRAIN : CALC) : ISSUE;
      DRAIN:   state_n = (outstanding == '0) ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  // arvalid is registered from the next state; outstanding only drops while waiting, so it holds until ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid_q     <= 1'b0;
      cur_addr      <= '0;
      rem           <= '0;
      arlen         <= '0;
      outstanding   <= '0;
      cmd_done      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      arvalid_q     <= (state_n == ISSUE) && (out_n < OW'(MAX_OUTSTANDING));
      outstanding   <= out_n;
      cmd_done      <= (accept && s_len == '0) || (state == DRAIN && outstanding == '0);
      err_underflow <= err_underflow || (r_last && outstanding == '0);
      if (accept) begin
        cur_addr <= s_addr & ~(ADDR_WIDTH'(DATA_BYTES - 1));
        rem      <= s_len;
      end else if (ar_hs) begin
        cur_addr <= cur_addr + (ADDR_WIDTH'(nb) << LOG_DB);
        rem      <= rem_nxt;
      end
      if (state == CALC) arlen <= 8'(nb_w - CW'(1));
    end
  end
endmodule

// File: tb/tb_axi_rd_burst_gen.sv
// tb_axi_rd_burst_gen: vector table of commands with expected AR bursts, scoreboarded against the AR channel.
module tb_axi_rd_burst_gen;
  logic        clk = 0, resetn = 0;
  logic        s_valid = 0, s_ready;
  logic [47:0] s_data = '0;
  logic        m_arvalid, m_arready = 0;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid = 0, m_rready = 0, m_rlast = 0;
  logic        busy, cmd_done, err_underflow;

  axi_rd_burst_gen #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rlast(m_rlast), .busy(busy), .cmd_done(cmd_done), .err_underflow(err_underflow));

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] a; logic [7:0] l;} ar_t;
  typedef struct {
    logic [31:0]      addr;
    logic [15:0]      len;
    int               n;
    logic [2:0][31:0] ea;
    logic [2:0][7:0]  el;
  } vec_t;

  ar_t  exp_q[$];
  vec_t vecs[$];
  int   n_chk = 0, n_fail = 0, pending = 0, done_seen = 0;
  bit   auto_r = 0, ar_rand = 0, ar_fixed = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [31:0] addr, input logic [15:0] len, input int n,
                         input logic [31:0] a0, input logic [7:0] l0, input logic [31:0] a1,
                         input logic [7:0] l1, input logic [31:0] a2, input logic [7:0] l2);
    vec_t v;
    v.addr = addr; v.len = len; v.n = n;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
    v.el[0] = l0; v.el[1] = l1; v.el[2] = l2;
    vecs.push_back(v);
  endtask

  task automatic sample();
    ar_t e;
    if (m_arvalid && m_arready) begin
      chk("ar_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("araddr", m_araddr, e.a);
        chk("arlen", m_arlen, e.l);
        chk("arsize", m_arsize, 3'd2);
        chk("arburst", m_arburst, 2'b01);
      end
      pending++;
    end
    if (m_rvalid && m_rready && m_rlast && pending > 0) pending--;
    if (cmd_done) done_seen++;
  endtask

  task automatic finish_cycle();
    @(posedge clk); #1;
    m_arready = ar_rand ? ($urandom_range(0, 3) != 0) : ar_fixed;
    if (auto_r) begin
      m_rvalid = pending > 0; m_rready = pending > 0; m_rlast = pending > 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk); sample(); finish_cycle();
  endtask

  task automatic service(input int max);
    int c = 0;
    auto_r = 1;
    while (done_seen == 0 && c < max) begin cycle(); c++; end
    chk("cmd_done_seen", 64'(done_seen), 1);
    chk("all_ars_issued", 64'(exp_q.size()), 0);
    chk("rlasts_before_done", 64'(pending), 0);
    @(negedge clk);
    chk("cmd_done_one_cycle", cmd_done, 0);
    chk("busy_after_done", busy, 0);
    sample(); finish_cycle();
  endtask

  task automatic send(input logic [31:0] addr, input logic [15:0] len);
    done_seen = 0;
    s_data = {addr, len}; s_valid = 1;
    @(negedge clk);
    chk("s_ready_idle", s_ready, 1);
    sample(); finish_cycle();
    s_valid = 0;
  endtask

  task automatic start_cmd(input vec_t v);
    for (int k = 0; k < v.n; k++) exp_q.push_back('{v.ea[k], v.el[k]});
    send(v.addr, v.len);
    @(negedge clk);
    chk("lat1_arvalid", m_arvalid, 0);
    chk("busy_active", busy, 1);
    chk("s_ready_active", s_ready, 0);
    sample(); finish_cycle();
    @(negedge clk);
    chk("lat2_arvalid", m_arvalid, 1);
    sample(); finish_cycle();
  endtask

  initial begin
    vec_t v;
    bit seen;
    add_vec(32'h1000, 8, 1, 32'h1000, 7, 0, 0, 0, 0);
    add_vec(32'h0000, 40, 3, 32'h0000, 15, 32'h0040, 15, 32'h0080, 7);
    add_vec(32'h0FF8, 10, 2, 32'h0FF8, 1, 32'h1000, 7, 0, 0);
    add_vec(32'h0003, 4, 1, 32'h0000, 3, 0, 0, 0, 0);
    add_vec(32'h0FFC, 2, 2, 32'h0FFC, 0, 32'h1000, 0, 0, 0);
    add_vec(32'h0FC0, 20, 2, 32'h0FC0, 15, 32'h1000, 3, 0, 0);
    add_vec(32'hFFFF_FFF0, 4, 1, 32'hFFFF_FFF0, 3, 0, 0, 0, 0);
    add_vec(32'h2000, 16, 1, 32'h2000, 15, 0, 0, 0, 0);

    #2;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_arlen", m_arlen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_err", err_underflow, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_arvalid", m_arvalid, 0);
      chk("post_rst_busy", busy, 0);
      finish_cycle();
    end

    foreach (vecs[i]) begin
      ar_rand = (i % 2) == 1; ar_fixed = 1;
      start_cmd(vecs[i]);
      service(300);
    end
    chk("no_underflow_yet", err_underflow, 0);

    // Outstanding limit of 2: 64 beats = four 16-beat bursts, rlast withheld.
    ar_rand = 0; ar_fixed = 1; auto_r = 0;
    v.addr = 0; v.len = 64; v.n = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back('{32'(k * 64), 8'd15});
    start_cmd(v);
    repeat (10) cycle();
    chk("limit_two_issued", 64'(exp_q.size()), 2);
    @(negedge clk);
    chk("limit_arvalid_low", m_arvalid, 0);
    sample();
    ar_fixed = 0;
    finish_cycle();
    m_rvalid = 1; m_rready = 1; m_rlast = 1;
    cycle();
    m_rvalid = 0; m_rready = 0; m_rlast = 0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (m_arvalid) seen = 1;
      sample(); finish_cycle();
    end
    chk("third_ar_after_rlast", seen, 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_arvalid", m_arvalid, 1);
      chk("stall_araddr", m_araddr, 32'h80);
      chk("stall_arlen", m_arlen, 15);
      sample(); finish_cycle();
    end
    ar_fixed = 1;
    service(300);

    // Zero-length command, then an rlast with nothing outstanding.
    auto_r = 0;
    send(32'h3000, 0);
    @(negedge clk);
    chk("len0_cmd_done", cmd_done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_arvalid", m_arvalid, 0);
    sample(); finish_cycle();
    @(negedge clk);
    chk("len0_done_pulse", cmd_done, 0);
    chk("len0_err_before", err_underflow, 0);
    finish_cycle();
    m_rvalid = 1; m_rready = 1; m_rlast = 1;
    @(posedge clk); #1;
    m_rvalid = 0; m_rready = 0; m_rlast = 0;
    chk("underflow_set", err_underflow, 1);
    repeat (3) @(posedge clk);
    #1 chk("underflow_sticky", err_underflow, 1);

    // Reset in the middle of a command with arvalid held high.
    ar_fixed = 0;
    v.addr = 0; v.len = 40; v.n = 0;
    exp_q.push_back('{32'h0, 8'd15});
    start_cmd(v);
    #2 resetn = 0;
    #1;
    chk("midrst_arvalid", m_arvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_err_clear", err_underflow, 0);
    exp_q.delete(); pending = 0;
    @(posedge clk); #1 resetn = 1;
    ar_fixed = 1;
    v.addr = 32'h2000; v.len = 4; v.n = 1;
    v.ea[0] = 32'h2000; v.el[0] = 3;
    start_cmd(v);
    service(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
